video_in_rgba_frame_gate: RTL and testbench

//  Parametrised frame gate + RGBA packer between the video-in scaler Avalon-ST source and the frame consumer.
//  On request, captures exactly one video packet of FRAME_PIXELS beats, appends alpha, buffers it in a FIFO,
//  and presents RGBA words with valid/ready. Discards non-video (control) packets and flags bad-length frames via sreset.

---
 rtl/video_in_rgba_frame_gate.sv | 182 ++++++++++++++++++
 tb/tb_video_in_rgba_frame_gate.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_in_rgba_frame_gate.sv
// rtl/video_in_rgba_frame_gate.sv - one-shot video frame gate with RGBA packing and show-ahead output FIFO.
// Define VIDEO_IN_OVERFLOW_DROP_EN to drop beats on FIFO overflow instead of back-pressuring the source.
module video_in_rgba_frame_gate #(
  parameter int                  CHANNELS     = 3,
  parameter int                  CH_WIDTH     = 8,
  parameter logic [CH_WIDTH-1:0] ALPHA        = {CH_WIDTH{1'b1}},
  parameter int                  FIFO_DEPTH   = 16,
  parameter int                  FRAME_PIXELS = 76800
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [CHANNELS*CH_WIDTH-1:0] sink_data,
  input  logic                         sink_startofpacket,
  input  logic                         sink_endofpacket,
  input  logic                         sink_valid,
  output logic                         sink_ready,
  output logic [4*CH_WIDTH-1:0]        rgba_image_data,
  output logic                         rgba_image_valid,
  input  logic                         rgba_image_ready,
  input  logic                         stream_control_arm,
  output logic                         stream_control_ready,
  output logic                         stream_control_sreset,
  output logic                         stream_control_endofpacket,
  output logic                         video_in_overflow_flag
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_PIXELS + 1);
  localparam int OW = 4 * CH_WIDTH;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME_PIXELS);

  typedef enum logic [2:0] {S_IDLE, S_SEEK, S_SKIP, S_STREAM, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            frame_drop_q, frame_drop_d;
  logic            sreset_q, sreset_d;
  logic            eop_q, eop_d;
  logic [OW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     fcnt_q;
  logic            fifo_full, fifo_empty, pop, push, room, accept, drop_evt, is_video;
  logic [OW-1:0]   pix_word;

  generate
    if (CHANNELS == 3) begin : g_alpha
      assign pix_word = {sink_data, ALPHA};
    end else begin : g_rgba
      assign pix_word = sink_data[OW-1:0];
    end
  endgenerate

  assign fifo_full  = (fcnt_q == DEPTH_C);
  assign fifo_empty = (fcnt_q == '0);
  assign pop        = rgba_image_ready & ~fifo_empty;
  // A pop in the same cycle frees the slot the incoming beat needs.
  assign room       = ~fifo_full | pop;
  assign accept     = sink_valid & sink_ready;
  assign is_video   = (sink_data[3:0] == 4'd0);
  assign cnt_inc    = cnt_q + 1'b1;

  assign rgba_image_data            = mem_q[rd_ptr_q];
  assign rgba_image_valid           = ~fifo_empty;
  assign stream_control_ready       = (state_q == S_IDLE);
  assign stream_control_sreset      = sreset_q;
  assign stream_control_endofpacket = eop_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_drop_d = frame_drop_q;
    sreset_d     = 1'b0;
    eop_d        = 1'b0;
    push         = 1'b0;
    drop_evt     = 1'b0;
    case (state_q)
      S_IDLE: if (stream_control_arm) state_d = S_SEEK;
      S_SEEK: begin
        if (accept && sink_startofpacket) begin
          if (is_video) begin
            state_d      = S_STREAM;
            cnt_d        = '0;
            frame_drop_d = 1'b0;
          end else if (!sink_endofpacket) begin
            state_d = S_SKIP;
          end
        end
      end
      S_SKIP: if (accept && sink_endofpacket) state_d = S_SEEK;
      S_STREAM: begin
        if (accept) begin
          if (sink_startofpacket) begin
            // A new header mid-frame abandons the current frame and restarts capture.
            sreset_d     = 1'b1;
            cnt_d        = '0;
            frame_drop_d = 1'b0;
            if (!is_video) state_d = sink_endofpacket ? S_SEEK : S_SKIP;
          end else begin
            if (cnt_q != FRAME_C) begin
              cnt_d    = cnt_inc;
              push     = room;
              drop_evt = ~room;
            end
            if (drop_evt) frame_drop_d = 1'b1;
            if (sink_endofpacket) begin
              if (cnt_q != FRAME_C && cnt_inc == FRAME_C && !frame_drop_q && room) begin
                state_d = S_DRAIN;
              end else begin
                sreset_d = 1'b1;
                state_d  = S_SEEK;
              end
            end
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          eop_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      frame_drop_q <= 1'b0;
      sreset_q     <= 1'b0;
      eop_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_drop_q <= frame_drop_d;
      sreset_q     <= sreset_d;
      eop_q        <= eop_d;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) mem_q[wr_ptr_q] <= pix_word;
  end

`ifdef VIDEO_IN_OVERFLOW_DROP_EN
  logic ovf_q;

  assign sink_ready             = 1'b1;
  assign video_in_overflow_flag = ovf_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_IDLE && stream_control_arm) begin
      ovf_q <= 1'b0;
    end else if (drop_evt) begin
      ovf_q <= 1'b1;
    end
  end
`else
  assign sink_ready             = (state_q != S_STREAM) | ~fifo_full;
  assign video_in_overflow_flag = 1'b0;
`endif

endmodule

// File: tb/tb_video_in_rgba_frame_gate.sv
// tb/tb_video_in_rgba_frame_gate.sv - directed bench for video_in_rgba_frame_gate (6-pixel frames, 4-deep FIFO).
module tb_video_in_rgba_frame_gate;
  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sink_data;
  logic        sink_sop, sink_eop, sink_valid, sink_ready;
  logic [31:0] rgba_data;
  logic        rgba_valid, rgba_ready;
  logic        arm, ctrl_ready, sreset, endofpacket, ovf_flag;

  int checks = 0;
  int errors = 0;
  int sreset_cnt = 0;
  int eop_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  video_in_rgba_frame_gate #(
    .CHANNELS(3), .CH_WIDTH(8), .ALPHA(8'hFF), .FIFO_DEPTH(4), .FRAME_PIXELS(6)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .sink_data(sink_data),
    .sink_startofpacket(sink_sop),
    .sink_endofpacket(sink_eop),
    .sink_valid(sink_valid),
    .sink_ready(sink_ready),
    .rgba_image_data(rgba_data),
    .rgba_image_valid(rgba_valid),
    .rgba_image_ready(rgba_ready),
    .stream_control_arm(arm),
    .stream_control_ready(ctrl_ready),
    .stream_control_sreset(sreset),
    .stream_control_endofpacket(endofpacket),
    .video_in_overflow_flag(ovf_flag)
  );

  typedef struct {
    logic        arm, valid, sop, eop;
    logic [23:0] data;
    logic        e_sink_ready, e_valid, e_ctrl_ready, e_sreset, e_eop;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Output-side scoreboard and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rgba_valid && rgba_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rgba_unexpected actual=%0h required=none", rgba_data);
        end else begin
          chk("rgba_word", rgba_data, exp_q.pop_front());
        end
      end
      if (sreset) sreset_cnt++;
      if (endofpacket) eop_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic send_beat(input logic sop, input logic eop, input logic [23:0] d);
    int n = 0;
    sink_valid = 1'b1;
    sink_sop   = sop;
    sink_eop   = eop;
    sink_data  = d;
    forever begin
      @(negedge clk);
      if (sink_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_beat_timeout actual=stalled required=accepted");
        break;
      end
    end
    tick(1);
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic send_pixels(input int npix, input logic [23:0] base, input bit last_eop, input bit expect_out);
    logic [23:0] d;
    for (int i = 0; i < npix; i++) begin
      d = base + 24'(i) * 24'h010101;
      if (expect_out) exp_q.push_back({d, 8'hFF});
      send_beat(1'b0, last_eop && (i == npix - 1), d);
    end
  endtask

  initial begin
    int s0, e0;
    rst = 1'b1; sink_data = '0; sink_sop = 0; sink_eop = 0; sink_valid = 0;
    rgba_ready = 1'b1; arm = 1'b0;

    tbl[0]  = '{1,0,0,0,24'h000000, 1,0,0,0,0, 32'h0};
    tbl[1]  = '{0,1,1,0,24'h000000, 1,0,0,0,0, 32'h0};
    tbl[2]  = '{0,1,0,0,24'h102030, 1,1,0,0,0, 32'h102030FF};
    tbl[3]  = '{0,1,0,0,24'h203040, 1,1,0,0,0, 32'h203040FF};
    tbl[4]  = '{0,1,0,0,24'h304050, 1,1,0,0,0, 32'h304050FF};
    tbl[5]  = '{0,1,0,0,24'h405060, 1,1,0,0,0, 32'h405060FF};
    tbl[6]  = '{0,1,0,0,24'h506070, 1,1,0,0,0, 32'h506070FF};
    tbl[7]  = '{0,1,0,1,24'h607080, 1,1,0,0,0, 32'h607080FF};
    tbl[8]  = '{0,0,0,0,24'h000000, 1,0,0,0,0, 32'h0};
    tbl[9]  = '{0,0,0,0,24'h000000, 1,0,1,0,1, 32'h0};
    tbl[10] = '{0,0,0,0,24'h000000, 1,0,1,0,0, 32'h0};

    tick(2);
    chk("rst_sink_ready", sink_ready, 1);
    chk("rst_ctrl_ready", ctrl_ready, 1);
    chk("rst_rgba_valid", rgba_valid, 0);
    chk("rst_sreset", sreset, 0);
    chk("rst_endofpacket", endofpacket, 0);
    chk("rst_overflow", ovf_flag, 0);
    rst = 1'b0;
    tick(1);

    // Good frame, consumer always ready: cycle-exact table.
    for (int i = 2; i < 8; i++) exp_q.push_back(tbl[i].e_data);
    for (int i = 0; i < 11; i++) begin
      arm = tbl[i].arm; sink_valid = tbl[i].valid; sink_sop = tbl[i].sop;
      sink_eop = tbl[i].eop; sink_data = tbl[i].data;
      tick(1);
      chk($sformatf("t1_sink_ready[%0d]", i), sink_ready, tbl[i].e_sink_ready);
      chk($sformatf("t1_valid[%0d]", i), rgba_valid, tbl[i].e_valid);
      chk($sformatf("t1_ctrl_ready[%0d]", i), ctrl_ready, tbl[i].e_ctrl_ready);
      chk($sformatf("t1_sreset[%0d]", i), sreset, tbl[i].e_sreset);
      chk($sformatf("t1_eop[%0d]", i), endofpacket, tbl[i].e_eop);
      if (tbl[i].e_valid) chk($sformatf("t1_data[%0d]", i), rgba_data, tbl[i].e_data);
    end
    arm = 0; sink_valid = 0; sink_sop = 0; sink_eop = 0;
    tick(2);
    sreset_cnt = 0; eop_cnt = 0;

    // Control packet is skipped, following video frame captured.
    arm_pulse();
    send_beat(1'b1, 1'b0, 24'h00000F);
    send_beat(1'b0, 1'b0, 24'hAAAAAA);
    send_beat(1'b0, 1'b0, 24'hAAAAAA);
    send_beat(1'b0, 1'b1, 24'hBBBBBB);
    send_beat(1'b1, 1'b0, 24'h000000);
    send_pixels(6, 24'h010203, 1'b1, 1'b1);
    tick(20);
    chk("t2_eop_cnt", eop_cnt, 1);
    chk("t2_sreset_cnt", sreset_cnt, 0);
    chk("t2_words_left", exp_q.size(), 0);
    chk("t2_ctrl_ready", ctrl_ready, 1);

    // Short frame -> sreset, back to SEEK; next good frame without re-arm.
    sreset_cnt = 0; eop_cnt = 0;
    arm_pulse();
    send_beat(1'b1, 1'b0, 24'h000000);
    send_pixels(5, 24'h200000, 1'b1, 1'b1);
    tick(3);
    chk("t3_sreset_cnt", sreset_cnt, 1);
    chk("t3_eop_cnt", eop_cnt, 0);
    chk("t3_ctrl_ready_seek", ctrl_ready, 0);
    chk("t3_sink_ready_seek", sink_ready, 1);
    send_beat(1'b1, 1'b0, 24'h000000);
    send_pixels(6, 24'h300000, 1'b1, 1'b1);
    tick(20);
    chk("t3b_eop_cnt", eop_cnt, 1);
    chk("t3b_sreset_cnt", sreset_cnt, 1);
    chk("t3b_words_left", exp_q.size(), 0);

    // Consumer stalled with a 4-deep FIFO and a 6-pixel frame.
    sreset_cnt = 0; eop_cnt = 0;
    rgba_ready = 1'b0;
    arm_pulse();
    send_beat(1'b1, 1'b0, 24'h000000);
    send_pixels(4, 24'h400000, 1'b0, 1'b1);
    @(negedge clk);
`ifdef VIDEO_IN_OVERFLOW_DROP_EN
    chk("t5_sink_ready_full", sink_ready, 1);
    #6;
    send_beat(1'b0, 1'b0, 24'h500000);
    send_beat(1'b0, 1'b1, 24'h510000);
    tick(2);
    chk("t5_overflow", ovf_flag, 1);
    chk("t5_sreset_cnt", sreset_cnt, 1);
    rgba_ready = 1'b1;
    tick(10);
    chk("t5_words_left", exp_q.size(), 0);
    chk("t5_eop_cnt", eop_cnt, 0);
    send_beat(1'b1, 1'b0, 24'h000000);
    send_pixels(6, 24'h600000, 1'b1, 1'b1);
    tick(20);
    chk("t5b_eop_cnt", eop_cnt, 1);
    chk("t5b_overflow_kept", ovf_flag, 1);
    arm_pulse();
    chk("t5b_overflow_cleared", ovf_flag, 0);
`else
    #6;
    exp_q.push_back({24'h440404, 8'hFF});
    exp_q.push_back({24'h450505, 8'hFF});
    sink_valid = 1'b1; sink_data = 24'h440404;
    tick(4);
    @(negedge clk);
    chk("t4_sink_ready_full", sink_ready, 0);
    chk("t4_rgba_valid", rgba_valid, 1);
    chk("t4_head_word", rgba_data, 32'h400000FF);
    #6;
    rgba_ready = 1'b1;
    send_beat(1'b0, 1'b0, 24'h440404);
    send_beat(1'b0, 1'b1, 24'h450505);
    tick(20);
    chk("t4_eop_cnt", eop_cnt, 1);
    chk("t4_sreset_cnt", sreset_cnt, 0);
    chk("t4_words_left", exp_q.size(), 0);
    arm_pulse();
    chk("t4_ctrl_ready_after_arm", ctrl_ready, 0);
`endif

    // Reset mid-STREAM: immediate return to reset values, no pulses.
    rgba_ready = 1'b0;
    send_beat(1'b1, 1'b0, 24'h000000);
    send_pixels(2, 24'h700000, 1'b0, 1'b0);
    chk("t6_pre_valid", rgba_valid, 1);
    s0 = sreset_cnt; e0 = eop_cnt;
    #2 rst = 1'b1;
    #1;
    chk("t6_sink_ready", sink_ready, 1);
    chk("t6_ctrl_ready", ctrl_ready, 1);
    chk("t6_rgba_valid", rgba_valid, 0);
    chk("t6_sreset", sreset, 0);
    chk("t6_endofpacket", endofpacket, 0);
    chk("t6_overflow", ovf_flag, 0);
    tick(1);
    rst = 1'b0;
    rgba_ready = 1'b1;
    tick(5);
    chk("t6_no_sreset", sreset_cnt, s0);
    chk("t6_no_eop", eop_cnt, e0);
    chk("t6_idle_ready", ctrl_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
